// File: rtl/cpu_pkg.sv
// Shared encodings for the EX-stage branch resolver: branch kinds, condition
// codes, NZCV bit positions and the redirect/flush FSM states.
package cpu_pkg;

    localparam logic [1:0] BR_NONE  = 2'b00;
    localparam logic [1:0] BR_B     = 2'b01;
    localparam logic [1:0] BR_CBZ   = 2'b10;
    localparam logic [1:0] BR_BCOND = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH1 = 2'd1,
        ST_FLUSH2 = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target: pc plus word offset (offset scaled by four), wrapping mod 2^64.
module branch_target_adder (
    input  logic [63:0] pc,
    input  logic [63:0] offset,
    output logic [63:0] target
);

    assign target = pc + (offset << 2);

endmodule

// File: rtl/cond_branch_resolve.sv
// Resolves branches in EX: decides taken, registers the target, and runs a
// two-cycle flush with a single redirect pulse. Also owns the NZCV register.
module cond_branch_resolve
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [1:0]  br_kind,
    input  logic [3:0]  cond,
    input  logic [63:0] pc_ex,
    input  logic [63:0] offset_ext,
    input  logic [63:0] reg_val,
    input  logic        set_flags,
    input  logic [3:0]  alu_flags,
    output logic        redirect,
    output logic [63:0] target,
    output logic        flush,
    output logic [3:0]  flags_q,
    output fsm_state_e  dbg_state
);

    fsm_state_e  state;
    logic [63:0] target_next;
    logic        qualified;
    logic        taken;

    branch_target_adder u_adder (
        .pc     (pc_ex),
        .offset (offset_ext),
        .target (target_next)
    );

    // Instructions arriving while a flush is in progress are being squashed.
    assign qualified = ex_valid && (state == ST_IDLE);
    assign dbg_state = state;

    always_comb begin
        taken = 1'b0;
        case (br_kind)
            BR_B:     taken = 1'b1;
            BR_CBZ:   taken = (reg_val == 64'd0);
            BR_BCOND: begin
                case (cond)
                    COND_EQ: taken = flags_q[FLAG_Z];
                    COND_NE: taken = !flags_q[FLAG_Z];
                    COND_GE: taken = (flags_q[FLAG_N] == flags_q[FLAG_V]);
                    COND_LT: taken = (flags_q[FLAG_N] != flags_q[FLAG_V]);
                    default: taken = 1'b0;
                endcase
            end
            default:  taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            redirect <= 1'b0;
            flush    <= 1'b0;
            target   <= 64'h0;
            flags_q  <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (qualified && taken) begin
                        state    <= ST_FLUSH1;
                        redirect <= 1'b1;
                        flush    <= 1'b1;
                        target   <= target_next;
                    end else begin
                        redirect <= 1'b0;
                        flush    <= 1'b0;
                    end
                end
                ST_FLUSH1: begin
                    state    <= ST_FLUSH2;
                    redirect <= 1'b0;
                    flush    <= 1'b1;
                end
                ST_FLUSH2: begin
                    state    <= ST_IDLE;
                    redirect <= 1'b0;
                    flush    <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    redirect <= 1'b0;
                    flush    <= 1'b0;
                end
            endcase
            // Flags update uses the old flags_q for this cycle's B.cond decision.
            if (qualified && set_flags) begin
                flags_q <= alu_flags;
            end
        end
    end

endmodule

// File: doc/cond_branch_resolve.md
COND_BRANCH_RESOLVE -- requirements
Module: cond_branch_resolve

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk and reset; the polarity and synchronicity are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 ex_valid  input  1  the EX-stage instruction is live (not a bubble).
REQ-005 br_kind  input  2  00 none, 01 B (unconditional), 10 CBZ, 11 B.cond.
REQ-006 cond  input  4  condition for B.cond: 0000 EQ, 0001 NE, 1010 GE, 1011 LT; any other value is never taken.
REQ-007 pc_ex  input  64  PC of the EX-stage instruction.
REQ-008 offset_ext  input  64  sign-extended word offset (CondAddr19 or BrAddr26, already extended to 64 bits).
REQ-009 reg_val  input  64  Rt operand, used by CBZ.
REQ-010 set_flags  input  1  the EX instruction writes NZCV.
REQ-011 alu_flags  input  4  {N,Z,C,V} produced by the EX-stage ALU.
REQ-012 redirect  output  1  one-cycle pulse: fetch SHALL load target.
REQ-013 target  output  64  registered branch target.
REQ-014 flush  output  1  squash the IF/ID instructions.
REQ-015 flags_q  output  4  architectural NZCV register.

Function
REQ-016 The target SHALL be computed as pc_ex + (offset_ext << 2), modulo 2^64; wrap-around is silent, and negative offsets rely on two's complement.
REQ-017 The taken decision, combinational from the EX inputs, SHALL be:
- B: always taken.
- CBZ: taken when reg_val == 0.
- B.cond, using flags_q:
  - EQ: taken when Z = 1.
  - NE: taken when Z = 0.
  - GE: taken when N == V.
  - LT: taken when N != V.
- br_kind 00: never taken.
REQ-018 The decision SHALL qualify only when ex_valid = 1 and the FSM is in IDLE.
REQ-019 The FSM SHALL have the states IDLE, FLUSH1 and FLUSH2.
REQ-020 In IDLE, a qualified taken branch SHALL move the FSM to FLUSH1 at the next edge and register target at the same edge.
REQ-021 The FSM SHALL step FLUSH1 -> FLUSH2 -> IDLE unconditionally.
REQ-022 redirect SHALL be 1 only while in FLUSH1 (exactly one cycle per taken branch, latency one cycle from the EX cycle).
REQ-023 flush SHALL be 1 in FLUSH1 and FLUSH2 (two cycles).
REQ-024 While in FLUSH1 or FLUSH2, ex_valid SHALL be ignored: a branch SHALL not be taken and flags_q SHALL not be updated.
REQ-025 flags_q SHALL load alu_flags at the edge where ex_valid = 1, set_flags = 1 and the FSM is in IDLE.
REQ-026 A B.cond SHALL read the flags_q value present during its EX cycle, so a flag-setting instruction that is immediately older is already visible.
REQ-027 target SHALL hold its last value when no branch is taken.
REQ-028 A not-taken branch SHALL produce no redirect or flush, and the FSM SHALL stay in IDLE.
REQ-029 Back-to-back taken branches SHALL produce one redirect: the younger branch arrives during FLUSH and is ignored.

Reset
REQ-030 On reset assertion, the block SHALL immediately set:
- FSM = IDLE
- redirect = 0
- flush = 0
- target = 64'h0
- flags_q = 4'b0000
REQ-031 Reset in the middle of a flush SHALL abort the flush at once, and no redirect SHALL follow after deassertion.
REQ-032 The first rising edge after reset deassertion SHALL evaluate the inputs normally.

Structure
REQ-033 A shared package cpu_pkg SHALL hold:
- the br_kind encoding constants;
- the cond encoding constants;
- the FSM state enum;
- the flag bit indices N=3, Z=2, C=1, V=0.
REQ-034 One sub-module SHALL compute the target: branch_target_adder (64-bit pc plus offset shifted left by two).
REQ-035 The condition check SHALL stay inline, with no further hierarchy.

Verification
REQ-036 Backward conditional branch: reset, then a B.cond LT with flags_q N=1, V=0, pc_ex 64'h100 and offset_ext = all ones (-1) -> target 64'hFC, redirect high for one cycle, flush high for two cycles.
REQ-037 CBZ both ways: reg_val 0 with offset 4 and pc 0x40 -> target 0x50 and redirect; reg_val 5 -> no redirect, flush stays 0.
REQ-038 Flag set then branch: a set_flags instruction with alu_flags 0100 is followed next cycle by B.cond EQ -> taken; with alu_flags 0000 -> not taken.
REQ-039 Back-to-back branches: two consecutive taken B instructions -> exactly one redirect, carrying the first target; a set_flags arriving during FLUSH leaves flags_q unchanged.
REQ-040 Reset mid-flush: reset asserted during FLUSH1 -> flush and redirect drop asynchronously, FSM is IDLE, and no pulse follows deassertion.
REQ-041 Address wrap-around: pc_ex 64'hFFFF_FFFF_FFFF_FFFC with offset 2 -> target 64'h4.
